// File: rtl/hub75_scan_datapath_pkg.sv
// Shared definitions for the HUB75 scan datapath.
// Holds the default geometry, the pixel field layout of a 12-bit frame-buffer
// word ({R[3:0], G[3:0], B[3:0]}) and a helper that picks one BCM bit-plane
// out of a pixel.
package hub75_scan_datapath_pkg;

    localparam int COLS_DEF       = 64;
    localparam int SCAN_ROWS_DEF  = 16;
    localparam int BPC_DEF        = 4;
    localparam int BASE_DELAY_DEF = 8;
    localparam int DLY_W_DEF      = 12;

    // Pixel field layout inside one 12-bit pixel.
    localparam int CH_W  = 4;
    localparam int PX_W  = 3 * CH_W;
    localparam int R_LSB = 2 * CH_W;
    localparam int G_LSB = CH_W;
    localparam int B_LSB = 0;

    // Colour bits for both panel halves as they appear on the connector.
    typedef struct packed {
        logic r0;
        logic g0;
        logic b0;
        logic r1;
        logic g1;
        logic b1;
    } panel_rgb_t;

    // One bit-plane of a pixel as {R, G, B}.
    function automatic logic [2:0] plane_rgb(input logic [PX_W-1:0] px, input int unsigned plane);
        return {px[R_LSB + plane], px[G_LSB + plane], px[B_LSB + plane]};
    endfunction

endpackage

// File: rtl/hub75_scan_datapath_if.sv
// Bus between the scan control FSM / frame-buffer RAM and the scan datapath.
//   control : active-low sync clears, increments, LD/SHD target control,
//             LATCH/NOE requests and the PX_CLK_EN column strobe
//   status  : ZR/ZC/ZD/ZI counter flags back to the FSM
//   memory  : read address {row, col} out, read data (1-cycle latency) in
// master = FSM/RAM side, slave = datapath side.
interface hub75_scan_datapath_if #(
    parameter int ADDR_W = 10
);
    logic              rst_r_n, rst_c_n, rst_d_n, rst_i_n;
    logic              inc_r, inc_c, inc_d, inc_i;
    logic              ld, shd;
    logic              latch, noe, px_clk_en;
    logic              zr, zc, zd, zi;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_rdata;

    modport master (
        output rst_r_n, rst_c_n, rst_d_n, rst_i_n,
        output inc_r, inc_c, inc_d, inc_i,
        output ld, shd, latch, noe, px_clk_en,
        output mem_rdata,
        input  zr, zc, zd, zi, mem_addr
    );

    modport slave (
        input  rst_r_n, rst_c_n, rst_d_n, rst_i_n,
        input  inc_r, inc_c, inc_d, inc_i,
        input  ld, shd, latch, noe, px_clk_en,
        input  mem_rdata,
        output zr, zc, zd, zi, mem_addr
    );
endinterface

// File: rtl/hub75_scan_datapath_scan_counter.sv
// Wrapping up-counter used for the row, column and bit-plane counters.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   i_clr_n    : sync active-low clear, wins over i_inc
//   i_inc      : advance by one, MAX wraps to 0
//   o_count    : current value
//   o_wrap     : high while the count sits at MAX
module scan_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);
    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == WIDTH'(MAX));

    // NOTE: state is updated with <= so every register samples pre-edge values;
    // the async reset and the sync clear are distinct: rst_n is in the
    // sensitivity list, i_clr_n is just the highest-priority data condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_at_max ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = w_at_max;
endmodule

// File: rtl/hub75_scan_datapath.sv
// HUB75 scan datapath: row/column/bit-plane/delay counters with zero flags for
// the control FSM, frame-buffer addressing, BCM bit-plane selection and a
// fixed 2-stage pipeline to the panel pins.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : FSM controls/flags and frame-buffer read port
//   o_r0/o_g0/o_b0      : upper-half colour bits
//   o_r1/o_g1/o_b1      : lower-half colour bits
//   o_row_a             : panel row address
//   o_pclk/o_lat/o_oe_n : panel shift clock, latch, blank
module hub75_scan_datapath
    import hub75_scan_datapath_pkg::*;
#(
    parameter int COLS       = COLS_DEF,
    parameter int SCAN_ROWS  = SCAN_ROWS_DEF,
    parameter int BPC        = BPC_DEF,
    parameter int BASE_DELAY = BASE_DELAY_DEF,
    parameter int DLY_W      = DLY_W_DEF,
    localparam int RA_W      = $clog2(SCAN_ROWS),
    localparam int COL_W     = $clog2(COLS),
    localparam int BIT_W     = (BPC > 1) ? $clog2(BPC) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hub75_scan_datapath_if.slave  bus,
    output logic                  o_r0,
    output logic                  o_g0,
    output logic                  o_b0,
    output logic                  o_r1,
    output logic                  o_g1,
    output logic                  o_b1,
    output logic [RA_W-1:0]       o_row_a,
    output logic                  o_pclk,
    output logic                  o_lat,
    output logic                  o_oe_n
);
    // The longest plane's OE window must fit in the delay counter.
    if ((longint'(BASE_DELAY) << (BPC - 1)) > ((longint'(1) << DLY_W) - 1)) begin : g_bad_dly_w
        $error("DLY_W too small for BASE_DELAY << (BPC-1)");
    end
    if (BPC > CH_W) begin : g_bad_bpc
        $error("BPC exceeds the colour channel width of the pixel");
    end

    logic [RA_W-1:0]  w_row;
    logic [COL_W-1:0] w_col;
    logic [BIT_W-1:0] w_bit;
    logic             w_col_wrap;
    logic             w_unused_row_wrap;
    logic             w_unused_bit_wrap;

    scan_counter #(.WIDTH(COL_W), .MAX(COLS - 1)) u_col_cnt (
        .clk(clk), .rst_n(rst_n), .i_clr_n(bus.rst_c_n), .i_inc(bus.inc_c),
        .o_count(w_col), .o_wrap(w_col_wrap)
    );
    scan_counter #(.WIDTH(RA_W), .MAX(SCAN_ROWS - 1)) u_row_cnt (
        .clk(clk), .rst_n(rst_n), .i_clr_n(bus.rst_r_n), .i_inc(bus.inc_r),
        .o_count(w_row), .o_wrap(w_unused_row_wrap)
    );
    scan_counter #(.WIDTH(BIT_W), .MAX(BPC - 1)) u_bit_cnt (
        .clk(clk), .rst_n(rst_n), .i_clr_n(bus.rst_i_n), .i_inc(bus.inc_i),
        .o_count(w_bit), .o_wrap(w_unused_bit_wrap)
    );

    // Delay counter saturates so a stalled FSM never sees ZD drop again.
    logic [DLY_W-1:0] r_dly;
    logic [DLY_W-1:0] r_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
        end else if (!bus.rst_d_n) begin
            r_dly <= '0;
        end else if (bus.inc_d && (r_dly != '1)) begin
            r_dly <= r_dly + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= DLY_W'(BASE_DELAY);
        end else if (bus.ld) begin
            r_target <= DLY_W'(BASE_DELAY);
        end else if (bus.shd) begin
            r_target <= {r_target[DLY_W-2:0], 1'b0};
        end
    end

    assign bus.zc       = w_col_wrap;
    assign bus.zr       = (w_row == '0);
    assign bus.zi       = (w_bit == '0);
    assign bus.zd       = (r_dly >= r_target);
    assign bus.mem_addr = {w_row, w_col};

    // Stage 1 lines the controls up with the RAM's 1-cycle read latency; the
    // plane index is captured too so it matches the word arriving next cycle.
    logic             r_px_d1, r_lat_d1, r_noe_d1;
    logic [RA_W-1:0]  r_row_d1;
    logic [BIT_W-1:0] r_bit_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px_d1  <= 1'b0;
            r_lat_d1 <= 1'b0;
            r_noe_d1 <= 1'b1;
            r_row_d1 <= '0;
            r_bit_d1 <= '0;
        end else begin
            r_px_d1  <= bus.px_clk_en;
            r_lat_d1 <= bus.latch;
            r_noe_d1 <= bus.noe;
            r_row_d1 <= w_row;
            r_bit_d1 <= w_bit;
        end
    end

    logic [2:0] w_upper_rgb;
    logic [2:0] w_lower_rgb;

    assign w_upper_rgb = plane_rgb(bus.mem_rdata[23:12], int'(r_bit_d1));
    assign w_lower_rgb = plane_rgb(bus.mem_rdata[11:0], int'(r_bit_d1));

    logic             r_px_d2, r_lat_d2, r_noe_d2;
    logic [RA_W-1:0]  r_row_d2;
    panel_rgb_t       r_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px_d2  <= 1'b0;
            r_lat_d2 <= 1'b0;
            r_noe_d2 <= 1'b1;
            r_row_d2 <= '0;
        end else begin
            r_px_d2  <= r_px_d1;
            r_lat_d2 <= r_lat_d1;
            r_noe_d2 <= r_noe_d1;
            r_row_d2 <= r_row_d1;
        end
    end

    // Colour only changes on shifted columns so the data lines stay quiet
    // between pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= '0;
        end else if (r_px_d1) begin
            r_rgb <= {w_upper_rgb, w_lower_rgb};
        end
    end

    assign o_r0    = r_rgb.r0;
    assign o_g0    = r_rgb.g0;
    assign o_b0    = r_rgb.b0;
    assign o_r1    = r_rgb.r1;
    assign o_g1    = r_rgb.g1;
    assign o_b1    = r_rgb.b1;
    assign o_row_a = r_row_d2;
    assign o_lat   = r_lat_d2;
    assign o_oe_n  = r_noe_d2;
    // PCLK is high only in the low half of the cycle, so its rising edge lands
    // mid-way through the data eye; r_px_d2 only changes while clk is high,
    // which keeps the gated clock free of glitches.
    assign o_pclk  = r_px_d2 & ~clk;
endmodule

// File: tb/tb_hub75_scan_datapath.sv
module tb_hub75_scan_datapath;
    import hub75_scan_datapath_pkg::*;

    localparam int COLS       = 64;
    localparam int SCAN_ROWS  = 16;
    localparam int BPC        = 4;
    localparam int BASE_DELAY = 8;
    localparam int DLY_MAX    = 4095;
    localparam int RA_W       = 4;
    localparam int ADDR_W     = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hub75_scan_datapath_if #(.ADDR_W(ADDR_W)) bus ();

    logic            r0, g0, b0, r1, g1, b1, pclk, lat, oe_n;
    logic [RA_W-1:0] row_a;

    hub75_scan_datapath dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .o_r0(r0), .o_g0(g0), .o_b0(b0), .o_r1(r1), .o_g1(g1), .o_b1(b1),
        .o_row_a(row_a), .o_pclk(pclk), .o_lat(lat), .o_oe_n(oe_n)
    );

    typedef struct packed {
        bit rst_r_n, rst_c_n, rst_d_n, rst_i_n;
        bit inc_r, inc_c, inc_d, inc_i;
        bit ld, shd, latch, noe, px;
    } stim_t;

    // What the panel must show two cycles after a given cycle's controls.
    typedef struct {
        bit px, latch, noe;
        int row, plane, addr;
    } hist_t;

    hist_t       hist[$];
    int          m_row, m_col, m_bit, m_dly, m_tgt;
    logic [5:0]  m_rgb;
    logic [23:0] mem [0:(1 << ADDR_W) - 1];
    logic [23:0] ram_pend;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    endtask

    function automatic stim_t idle_stim();
        stim_t s = '0;
        s.rst_r_n = 1; s.rst_c_n = 1; s.rst_d_n = 1; s.rst_i_n = 1; s.noe = 1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_r_n = ($urandom % 16) != 0;
        s.rst_c_n = ($urandom % 16) != 0;
        s.rst_d_n = ($urandom % 16) != 0;
        s.rst_i_n = ($urandom % 16) != 0;
        s.inc_r = ($urandom % 4) == 0;
        s.inc_c = $urandom % 2;
        s.inc_d = $urandom % 2;
        s.inc_i = ($urandom % 4) == 0;
        s.ld    = ($urandom % 16) == 0;
        s.shd   = ($urandom % 8) == 0;
        s.latch = ($urandom % 8) == 0;
        s.noe   = $urandom % 2;
        s.px    = $urandom % 2;
        return s;
    endfunction

    // Plane `p` of both pixels in a frame-buffer word, as {r0,g0,b0,r1,g1,b1}.
    function automatic logic [5:0] expect_rgb(input logic [23:0] w, input int p);
        int up = int'(w[23:12]);
        int lo = int'(w[11:0]);
        return {((up >> (8 + p)) % 2) != 0, ((up >> (4 + p)) % 2) != 0, ((up >> p) % 2) != 0,
                ((lo >> (8 + p)) % 2) != 0, ((lo >> (4 + p)) % 2) != 0, ((lo >> p) % 2) != 0};
    endfunction

    task automatic model_reset();
        hist_t idle = '{px: 0, latch: 0, noe: 1, row: 0, plane: 0, addr: 0};
        m_row = 0; m_col = 0; m_bit = 0; m_dly = 0; m_tgt = BASE_DELAY; m_rgb = '0;
        hist.delete();
        hist.push_back(idle);
        hist.push_back(idle);
    endtask

    task automatic drive(input stim_t s);
        bus.rst_r_n = s.rst_r_n; bus.rst_c_n = s.rst_c_n;
        bus.rst_d_n = s.rst_d_n; bus.rst_i_n = s.rst_i_n;
        bus.inc_r = s.inc_r; bus.inc_c = s.inc_c; bus.inc_d = s.inc_d; bus.inc_i = s.inc_i;
        bus.ld = s.ld; bus.shd = s.shd; bus.latch = s.latch; bus.noe = s.noe;
        bus.px_clk_en = s.px;
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input stim_t s);
        hist_t e, cur;
        e = hist[hist.size() - 2];
        check("zr", bus.zr, m_row == 0);
        check("zc", bus.zc, m_col == COLS - 1);
        check("zi", bus.zi, m_bit == 0);
        check("zd", bus.zd, m_dly >= m_tgt);
        check("mem_addr", bus.mem_addr, m_row * COLS + m_col);
        check("lat", lat, e.latch);
        check("oe_n", oe_n, e.noe);
        check("row_a", row_a, e.row);
        check("pclk", pclk, e.px);
        check("rgb", {r0, g0, b0, r1, g1, b1}, m_rgb);

        // Frame-buffer RAM: data for last cycle's address appears this cycle.
        bus.mem_rdata = ram_pend;
        ram_pend = mem[bus.mem_addr];
        drive(s);

        if (hist[hist.size() - 1].px)
            m_rgb = expect_rgb(mem[hist[hist.size() - 1].addr], hist[hist.size() - 1].plane);
        cur = '{px: s.px, latch: s.latch, noe: s.noe, row: m_row, plane: m_bit, addr: m_row * COLS + m_col};
        hist.push_back(cur);
        if (hist.size() > 4) void'(hist.pop_front());

        if (!s.rst_c_n) m_col = 0; else if (s.inc_c) m_col = (m_col + 1) % COLS;
        if (!s.rst_r_n) m_row = 0; else if (s.inc_r) m_row = (m_row + 1) % SCAN_ROWS;
        if (!s.rst_i_n) m_bit = 0; else if (s.inc_i) m_bit = (m_bit + 1) % BPC;
        if (!s.rst_d_n) m_dly = 0; else if (s.inc_d && m_dly < DLY_MAX) m_dly = m_dly + 1;
        if (s.ld) m_tgt = BASE_DELAY; else if (s.shd) m_tgt = (m_tgt * 2) % (DLY_MAX + 1);

        @(posedge clk);
        #1;
        check("pclk_clk_high", pclk, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_oe_n", oe_n, 1'b1);
        check("rst_lat", lat, 1'b0);
        check("rst_pclk", pclk, 1'b0);
        check("rst_zi", bus.zi, 1'b1);
        check("rst_zr", bus.zr, 1'b1);
        check("rst_zc", bus.zc, 1'b0);
        check("rst_zd", bus.zd, 1'b0);
        check("rst_row_a", row_a, 0);
        check("rst_rgb", {r0, g0, b0, r1, g1, b1}, 6'd0);
        drive(idle_stim());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        stim_t s;
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 24'($urandom);
        ram_pend = '0;
        bus.mem_rdata = '0;
        drive(idle_stim());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Column walk through the wrap.
        s = idle_stim(); s.inc_c = 1;
        repeat (COLS + 1) step(s);

        // Target load/shift, LD beating SHD, then count up to the target.
        s = idle_stim(); s.ld = 1; step(s);
        s = idle_stim(); s.shd = 1; repeat (3) step(s);
        s = idle_stim(); s.ld = 1; s.shd = 1; step(s);
        s = idle_stim(); s.rst_d_n = 0; step(s);
        s = idle_stim(); s.inc_d = 1; repeat (10) step(s);

        // Known upper red nibble 1010, shifted on plane 1 and then plane 2.
        for (int i = 1; i <= 16; i++) mem[m_row * COLS + ((m_col + i) % COLS)][23:20] = 4'b1010;
        s = idle_stim(); s.rst_i_n = 0; step(s);
        s = idle_stim(); s.inc_i = 1; step(s);
        s = idle_stim(); s.px = 1; s.inc_c = 1; repeat (4) step(s);
        s = idle_stim(); s.inc_i = 1; step(s);
        s = idle_stim(); s.px = 1; s.inc_c = 1; repeat (4) step(s);
        s = idle_stim(); repeat (3) step(s);

        // Full row shift followed by a latch and an OE window.
        s = idle_stim(); s.rst_c_n = 0; step(s);
        s = idle_stim(); s.px = 1; s.inc_c = 1; repeat (COLS) step(s);
        s = idle_stim(); s.latch = 1; step(s);
        s = idle_stim(); s.noe = 0; repeat (4) step(s);
        s = idle_stim(); repeat (3) step(s);

        // Row walk through the wrap; clear beats increment.
        s = idle_stim(); s.inc_r = 1; repeat (SCAN_ROWS + 1) step(s);
        s = idle_stim(); s.inc_c = 1; repeat (5) step(s);
        s = idle_stim(); s.rst_c_n = 0; s.inc_c = 1; s.rst_r_n = 0; s.inc_r = 1; repeat (2) step(s);

        // Delay saturation: target 2048, count well past 4095.
        s = idle_stim(); s.rst_d_n = 0; s.ld = 1; step(s);
        s = idle_stim(); s.shd = 1; repeat (8) step(s);
        s = idle_stim(); s.inc_d = 1; repeat (4100) step(s);
        s = idle_stim(); s.shd = 1; step(s);
        s = idle_stim(); s.ld = 1; step(s);
        s = idle_stim(); repeat (2) step(s);

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step(rand_stim());
        end
        s = idle_stim(); repeat (3) step(s);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
